ethernet_bus_bridge: RTL and testbench
======================================

# ethernet_bus_bridge

Parametrised host-side bridge between the core's memory-mapped peripheral request path and an external asynchronous-strobe Ethernet MAC (DM9000-class: CMD, CS#, IOR#, IOW#, shared data bus). It replaces fixed half-cycle strobing with a single-clock state machine. The state machine has programmable setup, strobe, hold and recovery counts, a configurable data width, and a ready handshake toward the bus. It sits between the data-bus interconnect and the board-level tri-state pad logic.

## Interface
- DATA_WIDTH, 16, chip data bus width; legal values 8, 16 or 32.
- SETUP_CYCLES, 1, cycles from CS# low to strobe low; must be ≥1.
- STROBE_CYCLES, 2, cycles IOR#/IOW# held low; must be ≥1.
- HOLD_CYCLES, 1, cycles CS# and data held after strobe high; must be ≥1.
- RECOVERY_CYCLES, 2, idle gap enforced between accesses; must be ≥1.
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- addr  in  1  drives CMD: 0 = index port, 1 = data port.
- wdata  in  32  write data; low DATA_WIDTH bits used.
- rdata  out  32  read data, zero-extended; reset 0.
- ready  out  1  one-cycle completion pulse; reset 0.
- busy  out  1  high in any state other than IDLE; reset 0.
- irq  out  1  interrupt to the controller; reset 0.
- eth_cmd  out  1  CMD pin; reset 0.
- eth_cs_n  out  1  chip select; reset 1.
- eth_ior_n  out  1  read strobe; reset 1.
- eth_iow_n  out  1  write strobe; reset 1.
- eth_sd_o  out  DATA_WIDTH  write data to pad; reset 0.
- eth_sd_oe  out  1  pad output enable; reset 0.
- eth_sd_i  in  DATA_WIDTH  data from pad.
- eth_intr  in  1  chip interrupt, asynchronous.
- eth_pwrst_n  out  1  constant 1.

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE.
- All chip-side outputs are registered; there are no combinational paths from req to the pins.
- IDLE with req=1: latch we, addr and wdata[DATA_WIDTH-1:0]; go to SETUP. Input changes after acceptance are ignored.
- SETUP (SETUP_CYCLES cycles):
  - eth_cs_n=0 and eth_cmd=latched addr.
  - For writes: eth_sd_oe=1 and eth_sd_o=latched data.
- STROBE (STROBE_CYCLES cycles): eth_ior_n=0 (read) or eth_iow_n=0 (write). CS#, CMD and data are unchanged.
- Read capture: at the clock edge ending the last STROBE cycle, rdata ← zero-extended eth_sd_i.
- HOLD (HOLD_CYCLES cycles): strobes high; CS#, CMD and write data are still driven.
- RECOVER (RECOVERY_CYCLES cycles):
  - eth_cs_n=1, eth_sd_oe=0, strobes high.
  - ready=1 in the first RECOVER cycle only.
  - req is ignored.
- Single down-counter, width $clog2 of the maximum count + 1. It is loaded with N-1 on entering each phase and advances the state at 0.
- rdata holds its value until the next read completes; writes never alter it.
- eth_sd_oe and a low strobe never coincide with eth_cs_n=1.

## Timing
- Access accepted in cycle 0. With S, P, H = setup, strobe, hold cycle counts:
  - SETUP occupies cycles 1..S.
  - STROBE occupies cycles S+1..S+P.
  - HOLD occupies cycles S+P+1..S+P+H.
  - ready is high in cycle S+P+H+1.
- Earliest next acceptance is cycle S+P+H+1+RECOVERY_CYCLES.
- req may remain high across the ready cycle; it is re-sampled only in IDLE.
- Reset asserted at any point: all outputs go immediately to their reset values and the FSM goes to IDLE. An in-flight access is dropped with no ready.
- req asserted during reset or in non-IDLE states: no effect.

## Configuration
- ETHERNET_IRQ_SYNC_EN defined: eth_intr passes through a two-flop synchronizer (reset 0). irq rises or falls 2 cycles after eth_intr.
- Not defined: irq = eth_intr combinationally, for chips already clocked synchronously to the bridge.

## Structure
- Shared package holds:
  - eth_bridge_state_t enum: IDLE, SETUP, STROBE, HOLD, RECOVER.
  - Default timing constants, e.g. ETH_DEFAULT_STROBE_CYCLES.
  - The legal DATA_WIDTH set.
- One sub-module, ethernet_irq_sync: the 2-flop synchronizer, instantiated only under ETHERNET_IRQ_SYNC_EN.

## Test plan
- Defaults; write, addr=0, wdata=0x00001234:
  - cs_n=0 and sd_oe=1 with sd_o=0x1234 in cycles 1–4.
  - iow_n=0 in cycles 2–3; cmd=0 throughout.
  - ready in cycle 5 only.
- Defaults; read, addr=1, sd_i=0xBEEF during strobe:
  - ior_n=0 in cycles 2–3, cmd=1, sd_oe=0 throughout.
  - rdata=0x0000BEEF at ready (cycle 5).
- req held high with back-to-back writes: second acceptance in cycle 7. cs_n=1 in cycles 5–6.
- rst_n pulsed low in cycle 2 of a write:
  - cs_n=1, iow_n=1, sd_oe=0 immediately; no ready.
  - A new request after reset completes normally.
- DATA_WIDTH=32, STROBE_CYCLES=4; read with sd_i=0xCAFEF00D: ior_n low cycles 2–5, ready in cycle 7, rdata=0xCAFEF00D.
- eth_intr 0→1: irq=1 two cycles later with ETHERNET_IRQ_SYNC_EN defined, same cycle without it.

Source files
------------

// File: rtl/ethernet_bus_bridge_pkg.sv
// Shared types and defaults for the host-side DM9000-class bus bridge:
// FSM state encoding, default timing counts and the legal data-width set.
package ethernet_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } eth_bridge_state_t;

    localparam int ETH_DEFAULT_DATA_WIDTH      = 16;
    localparam int ETH_DEFAULT_SETUP_CYCLES    = 1;
    localparam int ETH_DEFAULT_STROBE_CYCLES   = 2;
    localparam int ETH_DEFAULT_HOLD_CYCLES     = 1;
    localparam int ETH_DEFAULT_RECOVERY_CYCLES = 2;

    // Chip bus widths the pad ring supports.
    function automatic bit eth_width_legal(input int width);
        return (width == 8) || (width == 16) || (width == 32);
    endfunction

    function automatic int eth_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ethernet_irq_sync.sv
// Two-flop synchronizer bringing the chip's asynchronous interrupt into clk.
module ethernet_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ethernet_bus_bridge.sv
// Single-clock strobe sequencer toward a DM9000-class MAC with programmable
// setup/strobe/hold/recovery. Define ETHERNET_IRQ_SYNC_EN to synchronize eth_intr.
module ethernet_bus_bridge
    import ethernet_bus_bridge_pkg::*;
#(
    parameter int DATA_WIDTH      = ETH_DEFAULT_DATA_WIDTH,
    parameter int SETUP_CYCLES    = ETH_DEFAULT_SETUP_CYCLES,
    parameter int STROBE_CYCLES   = ETH_DEFAULT_STROBE_CYCLES,
    parameter int HOLD_CYCLES     = ETH_DEFAULT_HOLD_CYCLES,
    parameter int RECOVERY_CYCLES = ETH_DEFAULT_RECOVERY_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic                  addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  irq,
    output logic                  eth_cmd,
    output logic                  eth_cs_n,
    output logic                  eth_ior_n,
    output logic                  eth_iow_n,
    output logic [DATA_WIDTH-1:0] eth_sd_o,
    output logic                  eth_sd_oe,
    input  logic [DATA_WIDTH-1:0] eth_sd_i,
    input  logic                  eth_intr,
    output logic                  eth_pwrst_n
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_SETUP   = SETUP;
    localparam logic [2:0] ST_STROBE  = STROBE;
    localparam logic [2:0] ST_HOLD    = HOLD;
    localparam logic [2:0] ST_RECOVER = RECOVER;

    localparam int MAX_CNT = eth_max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RECOVERY_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_SETUP   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_STROBE  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RECOVER = CNT_W'(RECOVERY_CYCLES - 1);

    if (!eth_width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("ethernet_bus_bridge: DATA_WIDTH must be 8, 16 or 32");
    end

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic                  r_cmd;
    logic                  r_cs_n;
    logic                  r_ior_n;
    logic                  r_iow_n;
    logic                  r_sd_oe;
    logic [DATA_WIDTH-1:0] r_sd_o;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  w_irq;
    logic                  w_unused_wdata;

    // Pins are loaded from the transition into each phase so every chip-side
    // output comes straight from a flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_cmd   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_ior_n <= 1'b1;
            r_iow_n <= 1'b1;
            r_sd_oe <= 1'b0;
            r_sd_o  <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= CNT_SETUP;
                        r_we    <= we;
                        r_cmd   <= addr;
                        r_cs_n  <= 1'b0;
                        r_sd_oe <= we;
                        if (we) r_sd_o <= wdata[DATA_WIDTH-1:0];
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= CNT_STROBE;
                        r_ior_n <= r_we;
                        r_iow_n <= !r_we;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CNT_HOLD;
                        r_ior_n <= 1'b1;
                        r_iow_n <= 1'b1;
                        if (!r_we) r_rdata <= 32'(eth_sd_i);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RECOVER;
                        r_cnt   <= CNT_RECOVER;
                        r_cs_n  <= 1'b1;
                        r_sd_oe <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETHERNET_IRQ_SYNC_EN
    ethernet_irq_sync u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (eth_intr),
        .o_sync  (w_irq)
    );
`else
    assign w_irq = eth_intr;
`endif

    // wdata bits above DATA_WIDTH are dropped by design.
    assign w_unused_wdata = ^wdata;

    assign rdata       = r_rdata;
    assign ready       = r_ready;
    assign busy        = (r_state != ST_IDLE);
    assign irq         = w_irq;
    assign eth_cmd     = r_cmd;
    assign eth_cs_n    = r_cs_n;
    assign eth_ior_n   = r_ior_n;
    assign eth_iow_n   = r_iow_n;
    assign eth_sd_o    = r_sd_o;
    assign eth_sd_oe   = r_sd_oe;
    assign eth_pwrst_n = 1'b1;

endmodule

// File: tb/tb_ethernet_bus_bridge.sv
// Directed bench for ethernet_bus_bridge: default 16-bit instance plus a
// 32-bit / 4-cycle-strobe instance, checked cycle by cycle against hand masks.
module tb_ethernet_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0, req1, we, addr, eth_intr;
    logic [31:0] wdata;
    logic [15:0] sd_i0;
    logic [31:0] sd_i1;

    logic [31:0] rdata0, rdata1;
    logic        ready0, busy0, irq0, cmd0, cs_n0, ior_n0, iow_n0, sd_oe0, pwrst_n0;
    logic        ready1, busy1, irq1, cmd1, cs_n1, ior_n1, iow_n1, sd_oe1, pwrst_n1;
    logic [15:0] sd_o0;
    logic [31:0] sd_o1;

    ethernet_bus_bridge u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .irq(irq0),
        .eth_cmd(cmd0), .eth_cs_n(cs_n0), .eth_ior_n(ior_n0), .eth_iow_n(iow_n0),
        .eth_sd_o(sd_o0), .eth_sd_oe(sd_oe0), .eth_sd_i(sd_i0),
        .eth_intr(eth_intr), .eth_pwrst_n(pwrst_n0)
    );

    ethernet_bus_bridge #(.DATA_WIDTH(32), .STROBE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .irq(irq1),
        .eth_cmd(cmd1), .eth_cs_n(cs_n1), .eth_ior_n(ior_n1), .eth_iow_n(iow_n1),
        .eth_sd_o(sd_o1), .eth_sd_oe(sd_oe1), .eth_sd_i(sd_i1),
        .eth_intr(eth_intr), .eth_pwrst_n(pwrst_n1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Bit k of each history vector records the signal in cycle k after acceptance.
    logic [15:0] h_cs_low, h_oe, h_iow_low, h_ior_low, h_cmd, h_ready, h_busy;
    logic [31:0] v_rdata_rdy, v_sd_o_c2;

    task automatic run_access(input bit sel, input logic i_we, input logic i_addr,
                              input logic [31:0] i_wdata, input int n_cyc, input bit hold);
        bit got_rdy;
        got_rdy   = 1'b0;
        h_cs_low  = '0; h_oe = '0; h_iow_low = '0; h_ior_low = '0;
        h_cmd     = '0; h_ready = '0; h_busy = '0;
        v_rdata_rdy = '0; v_sd_o_c2 = '0;
        @(negedge clk);
        we = i_we; addr = i_addr; wdata = i_wdata;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            if (!hold) begin
                req0 = 1'b0; req1 = 1'b0;
                addr = ~i_addr; wdata = ~i_wdata;
            end
            h_cs_low[k]  = sel ? ~cs_n1  : ~cs_n0;
            h_oe[k]      = sel ? sd_oe1  : sd_oe0;
            h_iow_low[k] = sel ? ~iow_n1 : ~iow_n0;
            h_ior_low[k] = sel ? ~ior_n1 : ~ior_n0;
            h_cmd[k]     = sel ? cmd1    : cmd0;
            h_ready[k]   = sel ? ready1  : ready0;
            h_busy[k]    = sel ? busy1   : busy0;
            if (h_ready[k] && !got_rdy) begin
                got_rdy     = 1'b1;
                v_rdata_rdy = sel ? rdata1 : rdata0;
            end
            if (k == 2) v_sd_o_c2 = sel ? sd_o1 : {16'h0000, sd_o0};
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic seen_ready;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; addr = 1'b0;
        wdata = '0; sd_i0 = '0; sd_i1 = '0; eth_intr = 1'b0;

        // Reset values, with req asserted during reset to show it has no effect.
        #12;
        req0 = 1'b1;
        @(negedge clk);
        check("rst_cs_n",   cs_n0,  1'b1);
        check("rst_strobes", {ior_n0, iow_n0}, 2'b11);
        check("rst_sd_oe",  sd_oe0, 1'b0);
        check("rst_ready",  ready0, 1'b0);
        check("rst_busy",   busy0,  1'b0);
        check("rst_rdata",  rdata0, 32'h0);
        check("rst_pwrst",  pwrst_n0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", busy0, 1'b0);

        // Default write to index port.
        run_access(1'b0, 1'b1, 1'b0, 32'h0000_1234, 9, 1'b0);
        check("wr_cs_low",  h_cs_low,  16'h001E);
        check("wr_sd_oe",   h_oe,      16'h001E);
        check("wr_iow_low", h_iow_low, 16'h000C);
        check("wr_ior_low", h_ior_low, 16'h0000);
        check("wr_cmd",     h_cmd & 16'h001E, 16'h0000);
        check("wr_ready",   h_ready,   16'h0020);
        check("wr_busy",    h_busy,    16'h007E);
        check("wr_sd_o",    v_sd_o_c2, 32'h0000_1234);
        check("wr_rdata_untouched", rdata0, 32'h0);

        // Default read from data port.
        sd_i0 = 16'hBEEF;
        run_access(1'b0, 1'b0, 1'b1, 32'h0, 9, 1'b0);
        check("rd_ior_low", h_ior_low, 16'h000C);
        check("rd_iow_low", h_iow_low, 16'h0000);
        check("rd_cmd",     h_cmd & 16'h001E, 16'h001E);
        check("rd_sd_oe",   h_oe,      16'h0000);
        check("rd_ready",   h_ready,   16'h0020);
        check("rd_rdata",   v_rdata_rdy, 32'h0000_BEEF);

        // req held high: back-to-back writes, second accepted in cycle 7.
        sd_i0 = 16'h0000;
        run_access(1'b0, 1'b1, 1'b1, 32'h0000_5A5A, 13, 1'b1);
        check("b2b_cs_low", h_cs_low, 16'h0F1E);
        check("b2b_ready",  h_ready,  16'h1020);
        check("b2b_busy",   h_busy,   16'h3F7E);
        check("b2b_rdata_kept", rdata0, 32'h0000_BEEF);

        // Reset in cycle 2 of a write drops the access.
        @(negedge clk);
        we = 1'b1; addr = 1'b0; wdata = 32'h0000_00AA; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        check("pre_rst_iow_low", iow_n0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n",  cs_n0,  1'b1);
        check("midrst_iow_n", iow_n0, 1'b1);
        check("midrst_sd_oe", sd_oe0, 1'b0);
        check("midrst_busy",  busy0,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen_ready = seen_ready | ready0;
        end
        check("midrst_no_ready", seen_ready, 1'b0);
        run_access(1'b0, 1'b1, 1'b0, 32'h0000_0077, 9, 1'b0);
        check("post_rst_ready",  h_ready,  16'h0020);
        check("post_rst_cs_low", h_cs_low, 16'h001E);
        check("post_rst_sd_o",   v_sd_o_c2, 32'h0000_0077);

        // 32-bit, 4-cycle strobe instance.
        sd_i1 = 32'hCAFE_F00D;
        run_access(1'b1, 1'b0, 1'b0, 32'h0, 10, 1'b0);
        check("w32_ior_low", h_ior_low, 16'h003C);
        check("w32_cs_low",  h_cs_low,  16'h007E);
        check("w32_ready",   h_ready,   16'h0080);
        check("w32_rdata",   v_rdata_rdy, 32'hCAFE_F00D);

        // Interrupt path latency.
        @(negedge clk);
        eth_intr = 1'b1;
        #1;
`ifdef ETHERNET_IRQ_SYNC_EN
        check("irq_rise_c0", irq0, 1'b0);
        @(negedge clk);
        check("irq_rise_c1", irq0, 1'b0);
        @(negedge clk);
        check("irq_rise_c2", irq0, 1'b1);
`else
        check("irq_rise_c0", irq0, 1'b1);
`endif
        @(negedge clk);
        eth_intr = 1'b0;
        #1;
`ifdef ETHERNET_IRQ_SYNC_EN
        check("irq_fall_c0", irq0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("irq_fall_c2", irq0, 1'b0);
`else
        check("irq_fall_c0", irq0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
